// File: rtl/stream_input_buffer_pkg.sv
// Shared constants, dispatcher state encoding and the RTS hysteresis rule
// used by the stream input buffer.
package stream_input_buffer_pkg;

  localparam logic TRUE    = 1'b1;
  localparam logic FALSE   = 1'b0;
  localparam logic TRUE_n  = 1'b0;
  localparam logic FALSE_n = 1'b1;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_GAP  = 1'b1
  } disp_state_e;

  // rts_n level for a given fill: pause the host at the high mark, resume at the low mark.
  function automatic logic rts_hyst(input int unsigned fill,
                                    input int unsigned high_mark,
                                    input int unsigned low_mark,
                                    input logic        cur_rts_n);
    logic res;
    res = cur_rts_n;
    if (fill >= high_mark) begin
      res = FALSE_n;
    end else if (fill <= low_mark) begin
      res = TRUE_n;
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_input_buffer_byte_fifo.sv
// Byte FIFO on an inferred block RAM. The read port is a registered,
// enable-gated read, so a popped byte appears on rd_data the following cycle.
module byte_fifo
  import stream_input_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic [DEPTH_LOG2:0]   fill,
  output logic [DEPTH_LOG2:0]   fill_next,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned            DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]    DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic [7:0]            rd_data_q;
  logic                  wr_accept;
  logic                  rd_accept;

  // Fullness is judged before any same-cycle pop, so a write into a full FIFO is dropped.
  assign full      = (fill_q == DEPTH_CNT);
  assign empty     = (fill_q == '0);
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_accept, rd_accept})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      if (rd_accept) begin
        rd_data_q <= mem[rd_ptr_q];
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign fill      = fill_q;
  assign fill_next = fill_d;

endmodule

// File: rtl/stream_input_buffer.sv
// Buffers received bytes and hands them to terminal_stream one at a time,
// with RTS flow control toward the host and a sticky overflow flag.
module stream_input_buffer
  import stream_input_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RTS_HIGH   = 768,
  parameter int unsigned RTS_LOW    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            unicode,
  output logic                  unicode_available,
  input  logic                  ready_n,
  output logic                  rts_n,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  overflow,
  input  logic                  overflow_clear
);

  disp_state_e         state_q, state_d;
  logic                avail_q, avail_d;
  logic                rts_n_q, rts_n_d;
  logic                overflow_q, overflow_d;
  logic                rd_en;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DEPTH_LOG2:0] fill_next;

  byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (rx_valid),
    .wr_data  (rx_data),
    .rd_en    (rd_en),
    .rd_data  (unicode),
    .fill     (fill_level),
    .fill_next(fill_next),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // S_GAP gives terminal_stream's registered ready_n one cycle to react to a strobe.
  always_comb begin
    state_d = state_q;
    avail_d = FALSE;
    rd_en   = FALSE;
    case (state_q)
      S_WAIT: begin
        if (ready_n == TRUE_n && !fifo_empty) begin
          rd_en   = TRUE;
          avail_d = TRUE;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (rx_valid && fifo_full) begin
      overflow_d = TRUE;
    end else if (overflow_clear) begin
      overflow_d = FALSE;
    end
    rts_n_d = rts_hyst(32'(fill_next), RTS_HIGH, RTS_LOW, rts_n_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_WAIT;
      avail_q    <= FALSE;
      rts_n_q    <= FALSE_n;
      overflow_q <= FALSE;
    end else begin
      state_q    <= state_d;
      avail_q    <= avail_d;
      rts_n_q    <= rts_n_d;
      overflow_q <= overflow_d;
    end
  end

  assign unicode_available = avail_q;
  assign rts_n             = rts_n_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_stream_input_buffer.sv
// Randomized bench for stream_input_buffer: a queue-based reference model
// predicts every output each cycle.
module tb_stream_input_buffer;

  localparam int DEPTH_LOG2 = 10;
  localparam int DEPTH      = 1024;
  localparam int RTS_HIGH   = 768;
  localparam int RTS_LOW    = 256;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [7:0]          rx_data = '0;
  logic                rx_valid = 1'b0;
  logic [7:0]          unicode;
  logic                unicode_available;
  logic                ready_n = 1'b1;
  logic                rts_n;
  logic [DEPTH_LOG2:0] fill_level;
  logic                overflow;
  logic                overflow_clear = 1'b0;

  stream_input_buffer #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .RTS_HIGH  (RTS_HIGH),
    .RTS_LOW   (RTS_LOW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .unicode          (unicode),
    .unicode_available(unicode_available),
    .ready_n          (ready_n),
    .rts_n            (rts_n),
    .fill_level       (fill_level),
    .overflow         (overflow),
    .overflow_clear   (overflow_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] exp_unicode = 8'h00;
  logic       exp_strobe  = 1'b0;
  logic       exp_rts_n   = 1'b1;
  logic       exp_ovf     = 1'b0;
  bit         verbose     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model, compare every output.
  task automatic cycle(input logic v, input logic [7:0] d, input logic rn,
                       input logic oc, input logic rst);
    int  sz;
    bit  send;
    rx_valid       = v;
    rx_data        = d;
    ready_n        = rn;
    overflow_clear = oc;
    reset          = rst;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_unicode = 8'h00;
      exp_strobe  = 1'b0;
      exp_rts_n   = 1'b1;
      exp_ovf     = 1'b0;
    end else begin
      sz   = exp_q.size();
      // At most one byte every other cycle, only while the terminal is ready.
      send = !exp_strobe && !rn && (sz > 0);
      if (send) exp_unicode = exp_q.pop_front();
      if (v && sz == DEPTH) exp_ovf = 1'b1;
      else if (oc) exp_ovf = 1'b0;
      if (v && sz < DEPTH) exp_q.push_back(d);
      exp_strobe = send;
      if (exp_q.size() >= RTS_HIGH) exp_rts_n = 1'b1;
      else if (exp_q.size() <= RTS_LOW) exp_rts_n = 1'b0;
    end
    #1;
    check("avail", 32'(unicode_available), 32'(exp_strobe));
    check("fill", 32'(fill_level), 32'(exp_q.size()));
    check("rts_n", 32'(rts_n), 32'(exp_rts_n));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("unicode", 32'(unicode), 32'(exp_unicode));
    if (verbose && exp_strobe)
      $display("strobe unicode=%02h fill=%0d", unicode, fill_level);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 5000) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (guard >= 5000) check({tag, "_drain_timeout"}, 32'(guard), 32'(0));
  endtask

  initial begin
    int busy;
    logic [7:0] first_byte;

    // Reset state
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    $display("txn reset done fill=%0d rts_n=%0b", fill_level, rts_n);

    // Three bytes with the terminal ready
    verbose = 1'b1;
    cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    verbose = 1'b0;

    // Fill to the RTS high mark while busy, then release
    for (int i = 0; i < 768; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    $display("txn wrote 768 bytes fill=%0d rts_n=%0b", fill_level, rts_n);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drain("hyst");
    $display("txn drained fill=%0d rts_n=%0b", fill_level, rts_n);

    // Fill to full, overflow, clear, then check order
    first_byte = 8'($urandom);
    cycle(1'b1, first_byte, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'hEF, 1'b1, 1'b0, 1'b0);
    $display("txn full fill=%0d overflow=%0b", fill_level, overflow);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("first_after_full", 32'(unicode), 32'(first_byte));
    drain("full");
    $display("txn full drain done fill=%0d", fill_level);

    // Terminal busy for 20 cycles after each strobe
    busy = 0;
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), (busy > 0), 1'b0, 1'b0);
      if (exp_strobe) busy = 20;
      else if (busy > 0) busy--;
    end
    drain("busy");
    $display("txn busy-terminal run done fill=%0d", fill_level);

    // Continuous write, ready terminal, pointer wrap
    for (int i = 0; i < 2000; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    $display("txn streaming run fill=%0d", fill_level);
    drain("stream");

    // Fully random mix including overflow_clear
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0), 1'b0);
    $display("txn random run fill=%0d overflow=%0b", fill_level, overflow);
    drain("random");

    // Reset mid-operation while in the gap state
    for (int i = 0; i < 500; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("strobe_before_reset", 32'(unicode_available), 32'(1));
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("reset_fill", 32'(fill_level), 32'(0));
    check("reset_avail", 32'(unicode_available), 32'(0));
    check("reset_rts", 32'(rts_n), 32'(1));
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    $display("txn mid-op reset done fill=%0d rts_n=%0b", fill_level, rts_n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
